// File: rtl/text_scan_ctrl_pkg.sv
// Shared constants and types for the text-mode scan controller: font address
// layout, clear-FSM encoding and the default clear character.
package text_scan_ctrl_pkg;

    localparam int PIXEL_ROW_BIT = 5;
    localparam int PIXEL_COL_BIT = 4;
    localparam int ASCII_BIT     = 8;
    localparam int FONT_BIT      = ASCII_BIT + PIXEL_ROW_BIT + PIXEL_COL_BIT;

    localparam logic [ASCII_BIT-1:0] ASCII_SPACE        = 8'h20;
    localparam logic [ASCII_BIT-1:0] CLEAR_CHAR_DEFAULT = ASCII_SPACE;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    function automatic logic [FONT_BIT-1:0] font_address(
        input logic [ASCII_BIT-1:0]     ascii,
        input logic [PIXEL_ROW_BIT-1:0] row,
        input logic [PIXEL_COL_BIT-1:0] col
    );
        return {ascii, row, col};
    endfunction

endpackage

// File: rtl/text_buffer_ram.sv
// Simple dual-port character buffer: one synchronous write port, one
// synchronous read port with one cycle of latency (read-before-write).
module text_buffer_ram #(
    parameter int DEPTH  = 600,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_reg <= mem[raddr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/text_scan_ctrl.sv
// Text-mode scan controller: character buffer with bus write port and clear
// engine, plus a 3-stage pipeline from VGA timing to font lookup and pixel.
module text_scan_ctrl
    import text_scan_ctrl_pkg::*;
#(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 15,
    parameter int         ADDR_W     = 10,
    parameter int         BLINK_LOG2 = 5,
    parameter logic [7:0] CLEAR_CHAR = CLEAR_CHAR_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bus_wr_en,
    input  logic [ADDR_W-1:0]   bus_addr,
    input  logic [7:0]          bus_wdata,
    output logic                bus_ready,
    input  logic                clr_req,
    output logic                clr_busy,
    input  logic                cursor_en,
    input  logic [ADDR_W-1:0]   cursor_pos,
    input  logic                in_active,
    input  logic [9:0]          in_x,
    input  logic [9:0]          in_y,
    input  logic                in_hsync,
    input  logic                in_vsync,
    output logic [FONT_BIT-1:0] font_addr,
    input  logic [7:0]          font_data,
    output logic [7:0]          pix_out,
    output logic                out_active,
    output logic                out_hsync,
    output logic                out_vsync
);

    localparam int DEPTH = COLS * ROWS;

    clr_state_t        state_reg;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic              clr_busy_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_CLEAR;
            clr_cnt_reg  <= '0;
            clr_busy_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_reg    <= ST_CLEAR;
                        clr_cnt_reg  <= '0;
                        clr_busy_reg <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg    <= ST_IDLE;
                        clr_cnt_reg  <= '0;
                        clr_busy_reg <= 1'b0;
                    end else begin
                        clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
                    end
                end
                default: begin
                    state_reg    <= ST_IDLE;
                    clr_busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign clr_busy  = clr_busy_reg;
    assign bus_ready = ~clr_busy_reg;

    // The clear engine owns the write port while busy; bus writes are dropped then.
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [7:0]        ram_wdata;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = bus_addr;
        ram_wdata = bus_wdata;
        if (clr_busy_reg) begin
            ram_we    = 1'b1;
            ram_waddr = clr_cnt_reg;
            ram_wdata = CLEAR_CHAR;
        end else if (bus_wr_en && (int'(bus_addr) < DEPTH)) begin
            ram_we = 1'b1;
        end
    end

    logic              in_area;
    logic [ADDR_W-1:0] rd_idx;
    logic [7:0]        ram_q;

    always_comb begin
        in_area = (int'(in_x) < COLS * 16) && (int'(in_y) < ROWS * 32);
        rd_idx  = in_area ? ADDR_W'(int'(in_y[9:5]) * COLS + int'(in_x[9:4])) : '0;
    end

    text_buffer_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (8)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_idx),
        .rdata (ram_q)
    );

    logic [PIXEL_COL_BIT-1:0] col1_reg;
    logic [PIXEL_ROW_BIT-1:0] row1_reg;
    logic [ADDR_W-1:0]        idx1_reg;
    logic                     act1_reg, area1_reg, hs1_reg, vs1_reg;
    logic [BLINK_LOG2-1:0]    frame_cnt_reg;
    logic                     act2_reg, area2_reg, hs2_reg, vs2_reg, hit2_reg;
    logic [FONT_BIT-1:0]      font_addr_reg;
    logic [7:0]               pix_out_reg;
    logic                     out_active_reg, out_hsync_reg, out_vsync_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col1_reg       <= '0;
            row1_reg       <= '0;
            idx1_reg       <= '0;
            act1_reg       <= 1'b0;
            area1_reg      <= 1'b0;
            hs1_reg        <= 1'b0;
            vs1_reg        <= 1'b0;
            frame_cnt_reg  <= '0;
            act2_reg       <= 1'b0;
            area2_reg      <= 1'b0;
            hs2_reg        <= 1'b0;
            vs2_reg        <= 1'b0;
            hit2_reg       <= 1'b0;
            font_addr_reg  <= '0;
            pix_out_reg    <= '0;
            out_active_reg <= 1'b0;
            out_hsync_reg  <= 1'b0;
            out_vsync_reg  <= 1'b0;
        end else begin
            col1_reg  <= in_x[PIXEL_COL_BIT-1:0];
            row1_reg  <= in_y[PIXEL_ROW_BIT-1:0];
            idx1_reg  <= rd_idx;
            act1_reg  <= in_active;
            area1_reg <= in_area;
            hs1_reg   <= in_hsync;
            vs1_reg   <= in_vsync;
            if (in_vsync && !vs1_reg) begin
                frame_cnt_reg <= frame_cnt_reg + BLINK_LOG2'(1);
            end

            act2_reg      <= act1_reg;
            area2_reg     <= area1_reg;
            hs2_reg       <= hs1_reg;
            vs2_reg       <= vs1_reg;
            hit2_reg      <= cursor_en && frame_cnt_reg[BLINK_LOG2-1] && (idx1_reg == cursor_pos);
            font_addr_reg <= font_address(ram_q, row1_reg, col1_reg);

            pix_out_reg    <= (act2_reg && area2_reg) ? (font_data ^ {8{hit2_reg}}) : 8'h00;
            out_active_reg <= act2_reg;
            out_hsync_reg  <= hs2_reg;
            out_vsync_reg  <= vs2_reg;
        end
    end

    assign font_addr  = font_addr_reg;
    assign pix_out    = pix_out_reg;
    assign out_active = out_active_reg;
    assign out_hsync  = out_hsync_reg;
    assign out_vsync  = out_vsync_reg;

endmodule

// File: tb/tb_text_scan_ctrl.sv
// Bench for text_scan_ctrl: a screen-level model predicts every pixel from the
// buffer contents, glyph table, cursor and frame count; literals pin that model.
module tb_text_scan_ctrl;

    localparam int COLS  = 40;
    localparam int ROWS  = 15;
    localparam int DEPTH = COLS * ROWS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bus_wr_en;
    logic [9:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_ready;
    logic        clr_req;
    logic        clr_busy;
    logic        cursor_en;
    logic [9:0]  cursor_pos;
    logic        in_active;
    logic [9:0]  in_x;
    logic [9:0]  in_y;
    logic        in_hsync;
    logic        in_vsync;
    logic [16:0] font_addr;
    logic [7:0]  font_data;
    logic [7:0]  pix_out;
    logic        out_active;
    logic        out_hsync;
    logic        out_vsync;

    always #5 clk = ~clk;

    text_scan_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_wr_en  (bus_wr_en),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ready  (bus_ready),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy),
        .cursor_en  (cursor_en),
        .cursor_pos (cursor_pos),
        .in_active  (in_active),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_hsync   (in_hsync),
        .in_vsync   (in_vsync),
        .font_addr  (font_addr),
        .font_data  (font_data),
        .pix_out    (pix_out),
        .out_active (out_active),
        .out_hsync  (out_hsync),
        .out_vsync  (out_vsync)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_model [DEPTH];
    int         frames_model = 0;

    // Toy font: '1' is a vertical bar, 'a' a box, space blank, others a checkerboard.
    function automatic logic [7:0] glyph(input logic [7:0] c, input logic [4:0] r, input logic [3:0] k);
        int ri = int'(r);
        int ki = int'(k);
        case (c)
            8'h20:   return 8'h00;
            8'h31:   return (ri >= 4 && ri <= 27 && ki >= 6 && ki <= 8) ? 8'hFF : 8'h00;
            8'h61:   return (ri >= 12 && ri <= 27 && ki >= 3 && ki <= 12) ? 8'hFF : 8'h00;
            default: return (c[0] ^ r[0] ^ k[0]) ? 8'hFF : 8'h00;
        endcase
    endfunction

    assign font_data = glyph(font_addr[16:9], font_addr[8:4], font_addr[3:0]);

    typedef struct packed {
        logic [7:0] pix;
        logic       act;
        logic       hs;
        logic       vs;
    } out_t;

    function automatic out_t screen_model(input int x, input int y, input logic act,
                                          input logic hs, input logic vs);
        out_t o;
        int   idx;
        logic inv;
        o.pix = 8'h00;
        o.act = act;
        o.hs  = hs;
        o.vs  = vs;
        if (act && x < COLS * 16 && y < ROWS * 32) begin
            idx   = (y / 32) * COLS + x / 16;
            inv   = cursor_en && ((frames_model % 32) >= 16) && (idx == int'(cursor_pos));
            o.pix = glyph(mem_model[idx], 5'(y % 32), 4'(x % 16)) ^ (inv ? 8'hFF : 8'h00);
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-edge record of what the outputs must become two edges later.
    out_t ring [4];
    logic rst_ring [4];
    int   edge_n = 0;

    initial begin
        forever begin
            @(posedge clk);
            edge_n = edge_n + 1;
            rst_ring[edge_n % 4] = !rst_n;
            if (!rst_n) ring[edge_n % 4] = '0;
            else ring[edge_n % 4] = screen_model(int'(in_x), int'(in_y), in_active, in_hsync, in_vsync);
        end
    end

    initial begin
        out_t e;
        int   m;
        forever begin
            @(negedge clk);
            m = edge_n;
            if (m >= 2) begin
                if (rst_ring[m % 4] || rst_ring[(m - 1) % 4]) e = '0;
                else e = ring[(m - 2) % 4];
                chk("pix_out", {24'h0, pix_out}, {24'h0, e.pix});
                chk("out_active", {31'h0, out_active}, {31'h0, e.act});
                chk("out_hsync", {31'h0, out_hsync}, {31'h0, e.hs});
                chk("out_vsync", {31'h0, out_vsync}, {31'h0, e.vs});
                chk("bus_ready", {31'h0, bus_ready}, {31'h0, ~clr_busy});
            end
        end
    end

    task automatic drive_idle();
        in_active = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_hsync  = 1'b0;
        in_vsync  = 1'b0;
    endtask

    task automatic pix_at(input int x, input int y, input logic act);
        @(negedge clk);
        in_x      = 10'(x);
        in_y      = 10'(y);
        in_active = act;
        in_hsync  = ((x % 16) == 15);
        in_vsync  = 1'b0;
    endtask

    task automatic probe(input int x, input int y, input logic act, input logic [7:0] exp, input string name);
        pix_at(x, y, act);
        @(negedge clk);
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk(name, {24'h0, pix_out}, {24'h0, exp});
        $display("probe %s x=%0d y=%0d pix=%02h", name, x, y, pix_out);
    endtask

    task automatic scan_cell(input int col, input int row);
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < 16; k++)
                pix_at(col * 16 + k, row * 32 + r, 1'b1);
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        $display("scan cell col=%0d row=%0d done", col, row);
    endtask

    task automatic bus_write(input int addr, input logic [7:0] data, input logic exp_ready, input string name);
        @(negedge clk);
        bus_wr_en = 1'b1;
        bus_addr  = 10'(addr);
        bus_wdata = data;
        chk(name, {31'h0, bus_ready}, {31'h0, exp_ready});
        @(negedge clk);
        bus_wr_en = 1'b0;
        if (exp_ready && addr < DEPTH) mem_model[addr] = data;
        $display("write addr=%0d data=%02h ready=%0b", addr, data, exp_ready);
    endtask

    task automatic count_busy(input int pulse_at, output int n);
        n = 0;
        while (clr_busy && n < 2000) begin
            clr_req = (n == pulse_at);
            n++;
            @(negedge clk);
        end
        clr_req = 1'b0;
    endtask

    task automatic check_stays_idle(input string name);
        int s = 0;
        repeat (20) begin
            @(negedge clk);
            if (clr_busy) s++;
        end
        chk(name, 32'(s), 32'd0);
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        in_active = 1'b0;
        in_vsync  = 1'b1;
        @(negedge clk);
        in_vsync = 1'b0;
        frames_model++;
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        bus_wr_en  = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;
        clr_req    = 1'b0;
        cursor_en  = 1'b0;
        cursor_pos = '0;
        drive_idle();
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h20;

        // Reset state and initial clear
        repeat (3) @(negedge clk);
        chk("rst_pix_out", {24'h0, pix_out}, 32'h0);
        chk("rst_out_active", {31'h0, out_active}, 32'h0);
        chk("rst_clr_busy", {31'h0, clr_busy}, 32'h1);
        chk("rst_bus_ready", {31'h0, bus_ready}, 32'h0);
        rst_n = 1'b1;
        count_busy(-1, n);
        chk("init_clear_len", 32'(n), 32'd600);
        $display("initial clear busy cycles=%0d", n);
        chk("ready_after_clear", {31'h0, bus_ready}, 32'h1);
        for (int c = 0; c < DEPTH; c++) begin
            pix_at((c % COLS) * 16, (c / COLS) * 32, 1'b1);
            pix_at((c % COLS) * 16 + 1, (c / COLS) * 32, 1'b1);
        end
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        $display("all-cells sweep done");

        // Glyph '1' in cell 0
        bus_write(0, 8'h31, 1'b1, "wr0_ready");
        scan_cell(0, 0);
        probe(7, 13, 1'b1, 8'hFF, "one_y13_x7");
        probe(0, 0, 1'b1, 8'h00, "one_y0_x0");
        probe(6, 4, 1'b1, 8'hFF, "one_y4_x6");
        probe(9, 13, 1'b1, 8'h00, "one_y13_x9");

        // Writes during a clear are dropped; out-of-range writes are dropped
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (99) @(negedge clk);
        bus_write(3, 8'h58, 1'b0, "wr_during_clear_ready");
        count_busy(-1, n);
        chk("clear_len_with_write", 32'(101 + n), 32'd600);
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h20;
        probe(49, 0, 1'b1, 8'h00, "cell3_unchanged");
        scan_cell(3, 0);
        scan_cell(0, 0);
        bus_write(600, 8'h31, 1'b1, "wr600_ready");

        // Display area boundaries
        bus_write(0, 8'h31, 1'b1, "wr0b_ready");
        bus_write(40, 8'h31, 1'b1, "wr40_ready");
        bus_write(599, 8'h31, 1'b1, "wr599_ready");
        probe(631, 461, 1'b1, 8'hFF, "last_cell_inside");
        probe(647, 13, 1'b1, 8'h00, "x_beyond_640");
        probe(7, 493, 1'b1, 8'h00, "y_beyond_480");
        probe(7, 13, 1'b0, 8'h00, "inactive");
        scan_cell(39, 14);

        // Cursor blink on cell 0 holding 'a'
        bus_write(0, 8'h61, 1'b1, "wr_a_ready");
        @(negedge clk);
        cursor_en  = 1'b1;
        cursor_pos = 10'd0;
        probe(5, 20, 1'b1, 8'hFF, "cursor_frame0");
        scan_cell(0, 0);
        repeat (16) vsync_pulse();
        probe(0, 0, 1'b1, 8'hFF, "blink_inverted_bg");
        probe(5, 20, 1'b1, 8'h00, "blink_inverted_fg");
        probe(16, 0, 1'b1, 8'h00, "cursor_other_cell");
        scan_cell(0, 0);
        scan_cell(1, 0);
        repeat (16) vsync_pulse();
        probe(5, 20, 1'b1, 8'hFF, "blink_restored_fg");
        probe(0, 0, 1'b1, 8'h00, "blink_restored_bg");
        scan_cell(0, 0);
        @(negedge clk);
        cursor_en = 1'b0;

        // Reset mid-clear restarts the pass; clr_req while busy is ignored
        @(negedge clk);
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        frames_model = 0;
        count_busy(100, n);
        chk("restart_clear_len", 32'(n), 32'd600);
        $display("restarted clear busy cycles=%0d", n);
        check_stays_idle("no_extra_pass");
        for (int i = 0; i < DEPTH; i++) mem_model[i] = 8'h20;
        scan_cell(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
